// File: rtl/fp_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fp_mul_rr_scheduler
// Brief    : Round-robin sharing of one pipelined float multiplier between
//            NREQ requesters, with a lockstep tag pipe routing results back.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mul_rr_scheduler #(
    parameter int NREQ = 2,
    parameter int LAT  = 3,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [31*NREQ-1:0]   req_a,
    input  logic [31*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_error,
    output logic [NREQ-1:0]      req_ready,
    output logic                 mul_valid,
    output logic [30:0]          mul_a,
    output logic [30:0]          mul_b,
    output logic                 mul_error,
    output logic                 backprn,
    input  logic                 mul_ready,
    input  logic [30:0]          mul_float,
    input  logic                 mul_error_in,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [30:0]          rsp_float,
    output logic                 rsp_error,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic                 busy,
    output logic                 tag_err
);

    logic [IDW-1:0] r_ptr;
    logic [LAT-1:0] r_tv;
    logic [IDW-1:0] r_tid [LAT];
    logic           r_tag_err;

    logic           w_head_v;
    logic [IDW-1:0] w_head_id;
    logic           w_head_rdy;
    logic           w_any_hi;
    logic           w_any_lo;
    logic [IDW-1:0] w_gnt_hi;
    logic [IDW-1:0] w_gnt_lo;
    logic [IDW-1:0] w_gnt;
    logic           w_issue;
    logic [IDW-1:0] w_sel;

    assign w_head_v  = r_tv[LAT-1];
    assign w_head_id = r_tid[LAT-1];

    always_comb begin
        w_head_rdy = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_head_id) begin
                w_head_rdy = rsp_ready[i];
            end
        end
    end

    assign backprn = ~(w_head_v & ~w_head_rdy);

    // Round robin as two priority searches: lowest valid index at or above
    // the pointer, falling back to the lowest valid index overall (wrap).
    always_comb begin
        w_any_hi = 1'b0;
        w_any_lo = 1'b0;
        w_gnt_hi = '0;
        w_gnt_lo = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                w_any_lo = 1'b1;
                w_gnt_lo = IDW'(i);
                if (IDW'(i) >= r_ptr) begin
                    w_any_hi = 1'b1;
                    w_gnt_hi = IDW'(i);
                end
            end
        end
    end

    assign w_gnt   = w_any_hi ? w_gnt_hi : w_gnt_lo;
    assign w_issue = w_any_lo & backprn;
    assign w_sel   = w_issue ? w_gnt : r_ptr;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        mul_error = 1'b0;
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = w_issue & (IDW'(i) == w_gnt);
            rsp_valid[i] = w_head_v & mul_ready & (IDW'(i) == w_head_id);
            if (IDW'(i) == w_sel) begin
                mul_a     = req_a[31*i +: 31];
                mul_b     = req_b[31*i +: 31];
                mul_error = req_error[i];
            end
        end
    end

    assign mul_valid = w_issue;
    assign rsp_float = mul_float;
    assign rsp_error = mul_error_in;
    assign busy      = |r_tv;
    assign tag_err   = r_tag_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_tv      <= '0;
            r_tag_err <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                r_tid[i] <= '0;
            end
        end else begin
            if (mul_ready != w_head_v) begin
                r_tag_err <= 1'b1;
            end
            if (w_issue) begin
                r_ptr <= (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
            end
            // The tag pipe freezes with the multiplier so IDs stay aligned.
            if (backprn) begin
                for (int i = LAT - 1; i > 0; i--) begin
                    r_tv[i]  <= r_tv[i-1];
                    r_tid[i] <= r_tid[i-1];
                end
                r_tv[0]  <= w_issue;
                r_tid[0] <= w_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_mul_rr_scheduler
// Brief    : Self-checking bench with a multiplier model and an in-order,
//            age-based reference of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_mul_rr_scheduler;

    localparam int NREQ = 2;
    localparam int LAT  = 3;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [31*NREQ-1:0]  req_a;
    logic [31*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_error;
    logic [NREQ-1:0]     req_ready;
    logic                mul_valid;
    logic [30:0]         mul_a;
    logic [30:0]         mul_b;
    logic                mul_error;
    logic                backprn;
    logic                mul_ready;
    logic [30:0]         mul_float;
    logic                mul_error_in;
    logic [NREQ-1:0]     rsp_valid;
    logic [30:0]         rsp_float;
    logic                rsp_error;
    logic [NREQ-1:0]     rsp_ready;
    logic                busy;
    logic                tag_err;
    logic                inj;

    always #5 clk = ~clk;

    fp_mul_rr_scheduler #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_error(req_error),
        .req_ready(req_ready),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_error(mul_error),
        .backprn(backprn),
        .mul_ready(mul_ready), .mul_float(mul_float), .mul_error_in(mul_error_in),
        .rsp_valid(rsp_valid), .rsp_float(rsp_float), .rsp_error(rsp_error),
        .rsp_ready(rsp_ready),
        .busy(busy), .tag_err(tag_err)
    );

    // Truncating multiply of unsigned {E,M} floats with implicit leading one.
    function automatic logic [30:0] fmul(input logic [30:0] a, input logic [30:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
        if (p[47]) return {e[7:0] + 8'd1, p[46:24]};
        else       return {e[7:0], p[45:23]};
    endfunction

    // Multiplier model: LAT stages, all held while backprn is low.
    logic        env_v [LAT];
    logic [30:0] env_f [LAT];
    logic        env_e [LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) env_v[i] <= 1'b0;
        end else if (backprn) begin
            env_v[0] <= mul_valid;
            env_f[0] <= fmul(mul_a, mul_b);
            env_e[0] <= mul_error;
            for (int i = 1; i < LAT; i++) begin
                env_v[i] <= env_v[i-1];
                env_f[i] <= env_f[i-1];
                env_e[i] <= env_e[i-1];
            end
        end
    end

    assign mul_ready    = env_v[LAT-1] | inj;
    assign mul_float    = env_f[LAT-1];
    assign mul_error_in = env_e[LAT-1];

    // Reference: in-flight ops oldest first, each aged by advancing cycles.
    typedef struct {
        int          id;
        logic [30:0] res;
        logic        err;
        int          age;
    } op_t;

    op_t q[$];
    int  ref_ptr;
    bit  ref_terr;
    int  last_gnt;
    int  n_checks;
    int  n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are set at a negedge; check outputs, advance reference, next negedge.
    task automatic step();
        bit       head;
        int       hid;
        bit       stall;
        int       gnt;
        op_t      o;
        #1;
        head  = (q.size() > 0) && (q[0].age == LAT);
        hid   = head ? q[0].id : 0;
        stall = head && !rsp_ready[hid];
        gnt   = -1;
        if (!stall) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ref_ptr + k) % NREQ;
                if (req_valid[j] && gnt < 0) gnt = j;
            end
        end
        check("backprn", backprn, !stall);
        check("req_ready", req_ready, (gnt >= 0) ? (1 << gnt) : 0);
        check("mul_valid", mul_valid, gnt >= 0);
        if (gnt >= 0) begin
            check("mul_a", mul_a, req_a[31*gnt +: 31]);
            check("mul_b", mul_b, req_b[31*gnt +: 31]);
            check("mul_error", mul_error, req_error[gnt]);
        end
        check("rsp_valid", rsp_valid, (head && mul_ready) ? (1 << hid) : 0);
        if (head && mul_ready) begin
            check("rsp_float", rsp_float, q[0].res);
            check("rsp_error", rsp_error, q[0].err);
        end
        check("busy", busy, q.size() > 0);
        check("tag_err", tag_err, ref_terr);

        if (mul_ready != head) ref_terr = 1'b1;
        if (!stall) begin
            if (head) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (gnt >= 0) begin
                o.id  = gnt;
                o.res = fmul(req_a[31*gnt +: 31], req_b[31*gnt +: 31]);
                o.err = req_error[gnt];
                o.age = 1;
                q.push_back(o);
                ref_ptr = (gnt + 1) % NREQ;
            end
        end
        if (rst) begin
            q.delete();
            ref_ptr  = 0;
            ref_terr = 1'b0;
        end
        last_gnt = gnt;
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [30:0] a, input logic [30:0] b, input logic e);
        req_a[31*i +: 31] = a;
        req_b[31*i +: 31] = b;
        req_error[i]      = e;
    endtask

    function automatic logic [30:0] rnd_op();
        return {8'($urandom_range(100, 150)), 23'($urandom)};
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] pend;
        n_checks  = 0;
        n_err     = 0;
        ref_ptr   = 0;
        ref_terr  = 1'b0;
        rst       = 1'b1;
        inj       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_error = '0;
        rsp_ready = '1;
        @(negedge clk);
        @(negedge clk);
        reset_dut();

        // Single operation 1.0 * 2.0
        req_valid = 2'b01;
        set_lane(0, 31'h3F800000, 31'h40000000, 1'b0);
        step();
        check("t1_grant", last_gnt, 0);
        req_valid = 2'b00;
        step();
        step();
        #1;
        check("t1_rsp", {rsp_valid, rsp_float}, {2'b01, 31'h40000000});
        step();
        check("t1_idle", busy, 1'b0);

        // Alternating grants from a fresh pointer
        reset_dut();
        set_lane(0, rnd_op(), rnd_op(), 1'b0);
        set_lane(1, rnd_op(), rnd_op(), 1'b0);
        req_valid = 2'b11;
        for (int c = 0; c < 6; c++) begin
            step();
            check("t2_order", last_gnt, c % 2);
        end
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) step();

        // Stall on requester 1 head result
        req_valid = 2'b10;
        step();
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t3_stall", {backprn, req_ready}, 3'b000);
            step();
        end
        rsp_ready = 2'b11;
        req_valid = 2'b00;
        #1;
        check("t3_release", rsp_valid, 2'b10);
        step();
        for (int c = 0; c < 6; c++) step();

        // Error flag carried through
        set_lane(0, rnd_op(), rnd_op(), 1'b1);
        req_valid = 2'b01;
        #1;
        check("t4_mul_error", {mul_valid, mul_error}, 2'b11);
        step();
        req_valid = 2'b00;
        step();
        step();
        #1;
        check("t4_rsp_error", {rsp_valid, rsp_error}, 3'b011);
        step();
        set_lane(0, rnd_op(), rnd_op(), 1'b0);

        // Reset with operations in flight
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) step();
        req_valid = 2'b10;
        reset_dut();
        req_valid = 2'b11;
        #1;
        check("t5_after_rst", {busy, rsp_valid, backprn, req_ready}, 6'b0_00_1_01);
        step();
        req_valid = 2'b00;
        for (int c = 0; c < 4; c++) step();

        // Spurious multiplier result sets the sticky flag
        inj = 1'b1;
        step();
        inj = 1'b0;
        #1;
        check("t6_tag_err", {tag_err, rsp_valid}, 3'b100);
        for (int c = 0; c < 3; c++) step();
        reset_dut();
        #1;
        check("t6_cleared", tag_err, 1'b0);

        // Randomized traffic with held requests and random backpressure
        pend = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    set_lane(i, rnd_op(), rnd_op(), $urandom_range(0, 7) == 0);
                end
                rsp_ready[i] = $urandom_range(0, 3) != 0;
            end
            req_valid = pend;
            step();
            if (last_gnt >= 0) pend[last_gnt] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = '1;
        for (int c = 0; c < LAT + 2; c++) step();
        check("final_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_mul_rr_scheduler.md
Name: fp_mul_rr_scheduler

Overview:
- Shares one pipelined float multiplier between NREQ requesters, e.g. the Newton-iteration stages of the inverse-sqrt unit.
- Picks one request per cycle round-robin, drives the multiplier operands, and tracks each issued operation's requester ID through a tag pipe that advances in lockstep with the multiplier.
- Routes each result back to its originating requester.
- Stalls the multiplier through backprn when the destination requester cannot accept its result.

Parameters:
NREQ, 2, number of requesters (legal 2..4)
LAT, 3, multiplier latency in advancing cycles (backprn=1 cycles) from operand issue to result (legal 1..8)
IDW, 2, width of the requester ID tag; must satisfy 2**IDW >= NREQ

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester operation request
req_a  in  31*NREQ  operand A, unsigned float {E[7:0],M[22:0]}; requester i at bits [31*i+30:31*i]
req_b  in  31*NREQ  operand B, same packing
req_error  in  NREQ  per-requester error flag carried with operation
req_ready  out  NREQ  one-hot grant; request i consumed this cycle
mul_valid  out  1  operand valid to multiplier
mul_a  out  31  granted operand A
mul_b  out  31  granted operand B
mul_error  out  1  granted error flag
backprn  out  1  multiplier advance enable (1 = advance, 0 = hold all stages)
mul_ready  in  1  result valid from multiplier last stage
mul_float  in  31  multiplier result
mul_error_in  in  1  result error flag
rsp_valid  out  NREQ  one-hot result valid to requester
rsp_float  out  31  result (shared bus, qualified by rsp_valid)
rsp_error  out  1  result error flag
rsp_ready  in  NREQ  per-requester result accept
busy  out  1  any tag in flight
tag_err  out  1  sticky tag/result mismatch flag

Behaviour:
- State:
  - Round-robin pointer ptr (IDW bits).
  - Tag pipe of LAT entries {tv, tid}; tv is the valid bit, tid the requester ID. Entry LAT-1 is the head.
  - tag_err register.
- Reset (rst=1 at posedge): ptr=0, all tv=0, tag_err=0. The reset cycle wins over any simultaneous request or response.
  - After reset: rsp_valid=0, backprn=1, busy=0, req_ready=0 unless requests present.
- Head: head_v = tv[LAT-1]; head_id = tid[LAT-1].
- Stall: backprn = ~(head_v & ~rsp_ready[head_id]). Combinational.
- Response (combinational):
  - rsp_valid[head_id] = head_v & mul_ready; all other rsp_valid bits 0.
  - rsp_float = mul_float; rsp_error = mul_error_in.
  - Result handed off when rsp_valid & rsp_ready at the same index (backprn=1).
- Arbitration (combinational), only when backprn=1:
  - Grant g = first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[g]=1; mul_valid=1; mul_a/mul_b/mul_error = lane g.
  - No request, or backprn=0: req_ready=0, mul_valid=0, operand outputs = lane ptr (don't care).
- Pointer: on issue, ptr <= (g+1) mod NREQ; otherwise hold.
- Tag pipe: when backprn=1, every entry shifts by one and entry 0 <= {issue, g}. When backprn=0, all entries hold.
  - LAT=1: the single entry is both entry 0 and head.
- Latency: an operation issued at cycle t with no stalls has rsp_valid at cycle t+LAT. Each stalled cycle adds one.
- Throughput: one issue per cycle. Back-to-back issue and retire in the same cycle is legal.
- Consistency: at any cycle, mul_ready != head_v sets tag_err <= 1. It stays set until rst; operation otherwise continues.
- busy = OR of all tv.
- Requesters with req_valid=0 are skipped with no bubble. A lone requester is granted every cycle.
- Requesters must hold req_* stable until req_ready. The block does not latch unconsumed requests.

Test Plan:
1. After reset, req_valid=01, req_a[0]=31'h3F800000 (1.0), req_b[0]=31'h40000000 (2.0), model multiplier with LAT=3.
   -> req_ready=01 at t0; rsp_valid=01 with rsp_float=31'h40000000 at t0+3; busy=0 after.
2. Both requesters held valid for 6 cycles, rsp_ready=11.
   -> grants 01,10,01,10,01,10; responses return in the same ID order 3 cycles later; no stall.
3. Head result for requester 1 with rsp_ready[1]=0 for 4 cycles.
   -> backprn=0, req_ready=00, tag pipe and ptr frozen for 4 cycles; result delivered the cycle rsp_ready[1]=1; later results delayed by 4.
4. req_error[0]=1 on a request, model returns mul_error_in=1.
   -> mul_error=1 at issue; rsp_error=1 with rsp_valid=01 at t0+3.
5. Assert rst while 3 operations are in flight.
   -> next cycle: busy=0, rsp_valid=00, backprn=1, ptr=0 (first grant goes to requester 0 if both valid).
6. Drive mul_ready=1 with no tag in flight.
   -> tag_err=1 on the next cycle, stays 1 until rst; rsp_valid stays 00.
